// File: rtl/cmp_arbiter_pkg.sv
// Shared types for the two-requester branch-comparator arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cmp_arbiter_pkg;

   // Default operand width of the shared comparator
   localparam int CMPARB_WIDTH = 32;

   // Arbiter sequencing states
   typedef enum logic {
      IDLE = 1'b0,
      CMP  = 1'b1
   } state_t;

   // Requester identifier
   typedef logic reqId_t;

   localparam reqId_t REQ0 = 1'b0;
   localparam reqId_t REQ1 = 1'b1;

endpackage

// File: rtl/cmp_arbiter_core.sv
// Shared comparator: a!=b and signed a<b from one subtract plus overflow.
// Latency: purely combinational.
// Backpressure: none; fed from the arbiter's latched operand registers.
module cmp_core #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             neq,
   output logic             lt
);

   logic [WIDTH-1:0] diff;
   logic             ovf;

   // Subtract once; sign of the difference corrected by overflow gives signed less-than
   always_comb begin
      diff = a - b;
      // Overflow only when operand signs differ and the result sign flips away from a
      ovf  = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      neq  = |diff;
      lt   = diff[WIDTH-1] ^ ovf;
   end

endmodule

// File: rtl/cmp_arbiter.sv
// Arbitrates two requesters onto one comparator; round-robin tie break, or req0 priority with CMPARB_FIXED_PRIO_EN.
// Latency: accept edge -> result registered one edge later; one compare per 2 cycles.
// Backpressure: readyN only for the granted valid requester in IDLE; both ready low while busy or in reset.
module cmp_arbiter
   import cmp_arbiter_pkg::*;
#(
   parameter int WIDTH = CMPARB_WIDTH
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   output logic             rsp0_valid,
   output logic             rsp0_neq,
   output logic             rsp0_lt,
   output logic             rsp1_valid,
   output logic             rsp1_neq,
   output logic             rsp1_lt,
   output logic             busy
);

   state_t           state;
   reqId_t           grantId;     // requester being served while in CMP
   reqId_t           nextGrant;   // requester that would win in IDLE this cycle
   logic [WIDTH-1:0] opA;
   logic [WIDTH-1:0] opB;
   logic             cmpNeq;
   logic             cmpLt;
   logic             idleOk;
   logic             accept;
`ifndef CMPARB_FIXED_PRIO_EN
   reqId_t           lastGrant;
`endif

   // Pick the winner: a lone requester wins outright, ties go by priority policy
   always_comb begin
      nextGrant = REQ0;
      if (req0_valid && req1_valid) begin
`ifdef CMPARB_FIXED_PRIO_EN
         nextGrant = REQ0;
`else
         nextGrant = ~lastGrant;
`endif
      end else if (req1_valid) begin
         nextGrant = REQ1;
      end
   end

   assign idleOk     = !reset && (state == IDLE);
   assign req0_ready = idleOk && req0_valid && (nextGrant == REQ0);
   assign req1_ready = idleOk && req1_valid && (nextGrant == REQ1);
   assign accept     = req0_ready || req1_ready;
   assign busy       = (state == CMP);

   cmp_core #(
      .WIDTH (WIDTH)
   ) u_core (
      .a   (opA),
      .b   (opB),
      .neq (cmpNeq),
      .lt  (cmpLt)
   );

   // Sequencer: latch operands on accept, register the result into the winner's response port
   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= IDLE;
         grantId    <= REQ0;
         opA        <= '0;
         opB        <= '0;
         rsp0_valid <= 1'b0;
         rsp0_neq   <= 1'b0;
         rsp0_lt    <= 1'b0;
         rsp1_valid <= 1'b0;
         rsp1_neq   <= 1'b0;
         rsp1_lt    <= 1'b0;
`ifndef CMPARB_FIXED_PRIO_EN
         lastGrant  <= REQ1;
`endif
      end else begin
         rsp0_valid <= 1'b0;
         rsp1_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  opA     <= (nextGrant == REQ1) ? req1_a : req0_a;
                  opB     <= (nextGrant == REQ1) ? req1_b : req0_b;
                  grantId <= nextGrant;
`ifndef CMPARB_FIXED_PRIO_EN
                  lastGrant <= nextGrant;
`endif
                  state   <= CMP;
               end
            end
            CMP: begin
               if (grantId == REQ0) begin
                  rsp0_valid <= 1'b1;
                  rsp0_neq   <= cmpNeq;
                  rsp0_lt    <= cmpLt;
               end else begin
                  rsp1_valid <= 1'b1;
                  rsp1_neq   <= cmpNeq;
                  rsp1_lt    <= cmpLt;
               end
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cmp_arbiter.sv
// Directed bench for cmp_arbiter: single requests, signed extremes, ties, busy backpressure, reset mid-compare.
// Latency: expects result pulse in the cycle after the edge following accept.
// Backpressure: holds valid/operands until ready is observed.
module tb_cmp_arbiter;

   logic        clock;
   logic        reset;
   logic        req0_valid;
   logic        req0_ready;
   logic [31:0] req0_a;
   logic [31:0] req0_b;
   logic        req1_valid;
   logic        req1_ready;
   logic [31:0] req1_a;
   logic [31:0] req1_b;
   logic        rsp0_valid;
   logic        rsp0_neq;
   logic        rsp0_lt;
   logic        rsp1_valid;
   logic        rsp1_neq;
   logic        rsp1_lt;
   logic        busy;

   int vecCount  = 0;
   int missCount = 0;

   cmp_arbiter #(
      .WIDTH (32)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .req0_valid (req0_valid),
      .req0_ready (req0_ready),
      .req0_a     (req0_a),
      .req0_b     (req0_b),
      .req1_valid (req1_valid),
      .req1_ready (req1_ready),
      .req1_a     (req1_a),
      .req1_b     (req1_b),
      .rsp0_valid (rsp0_valid),
      .rsp0_neq   (rsp0_neq),
      .rsp0_lt    (rsp0_lt),
      .rsp1_valid (rsp1_valid),
      .rsp1_neq   (rsp1_neq),
      .rsp1_lt    (rsp1_lt),
      .busy       (busy)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vecCount++;
      if (got !== exp) begin
         missCount++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic checkAllZero(input string tag);
      chk({tag, "_rdy0"}, req0_ready, 0);
      chk({tag, "_rdy1"}, req1_ready, 0);
      chk({tag, "_rv0"},  rsp0_valid, 0);
      chk({tag, "_neq0"}, rsp0_neq,   0);
      chk({tag, "_lt0"},  rsp0_lt,    0);
      chk({tag, "_rv1"},  rsp1_valid, 0);
      chk({tag, "_neq1"}, rsp1_neq,   0);
      chk({tag, "_lt1"},  rsp1_lt,    0);
      chk({tag, "_busy"}, busy,       0);
   endtask

   // Lone request from one side; starts and ends on a falling edge with the arbiter idle
   task automatic singleReq(input string tag, input int id, input logic [31:0] a, input logic [31:0] b,
                            input logic expNeq, input logic expLt);
      if (id == 0) begin
         req0_valid = 1'b1; req0_a = a; req0_b = b;
      end else begin
         req1_valid = 1'b1; req1_a = a; req1_b = b;
      end
      #1;
      chk({tag, "_rdy0"}, req0_ready, (id == 0));
      chk({tag, "_rdy1"}, req1_ready, (id == 1));
      @(negedge clock);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      #1;
      chk({tag, "_busy"}, busy, 1);
      chk({tag, "_cmp_rdy0"}, req0_ready, 0);
      chk({tag, "_cmp_rdy1"}, req1_ready, 0);
      @(negedge clock);
      chk({tag, "_rv0"}, rsp0_valid, (id == 0));
      chk({tag, "_rv1"}, rsp1_valid, (id == 1));
      chk({tag, "_idle"}, busy, 0);
      chk({tag, "_neq"}, (id == 0) ? rsp0_neq : rsp1_neq, expNeq);
      chk({tag, "_lt"},  (id == 0) ? rsp0_lt  : rsp1_lt,  expLt);
      @(negedge clock);
      chk({tag, "_rv0_drop"}, rsp0_valid, 0);
      chk({tag, "_rv1_drop"}, rsp1_valid, 0);
   endtask

   initial begin
      int expGrant;
      reset      = 1'b1;
      req0_valid = 1'b0; req0_a = '0; req0_b = '0;
      req1_valid = 1'b0; req1_a = '0; req1_b = '0;

      // Reset state, with a request present during reset
      @(negedge clock);
      @(negedge clock);
      req0_valid = 1'b1;
      #1;
      checkAllZero("rst");
      @(negedge clock);
      reset      = 1'b0;
      req0_valid = 1'b0;

      // Single requests and signed extremes
      singleReq("r0_5_7",  0, 32'd5,        32'd7,        1'b1, 1'b1);
      singleReq("r0_min",  0, 32'h80000000, 32'h7FFFFFFF, 1'b1, 1'b1);
      singleReq("r1_max",  1, 32'h7FFFFFFF, 32'h80000000, 1'b1, 1'b0);
      chk("hold_neq0", rsp0_neq, 1);
      chk("hold_lt0",  rsp0_lt,  1);

      // Ties with equal operands: alternating grants starting at requester 0
      req0_valid = 1'b1; req0_a = 32'h10; req0_b = 32'h10;
      req1_valid = 1'b1; req1_a = 32'h10; req1_b = 32'h10;
      expGrant = 0;
      for (int i = 0; i < 5; i++) begin
         #1;
         if (i > 0) begin
            chk("tie_rv0",  rsp0_valid, (expGrant == 0));
            chk("tie_rv1",  rsp1_valid, (expGrant == 1));
            chk("tie_neq",  (expGrant == 0) ? rsp0_neq : rsp1_neq, 0);
            chk("tie_lt",   (expGrant == 0) ? rsp0_lt  : rsp1_lt,  0);
`ifndef CMPARB_FIXED_PRIO_EN
            expGrant = 1 - expGrant;
`endif
         end
         if (i < 4) begin
            chk("tie_rdy0", req0_ready, (expGrant == 0));
            chk("tie_rdy1", req1_ready, (expGrant == 1));
            @(negedge clock);
            #1;
            chk("tie_busy", busy, 1);
            chk("tie_bp0", req0_ready, 0);
            chk("tie_bp1", req1_ready, 0);
            @(negedge clock);
         end else begin
            req0_valid = 1'b0;
            req1_valid = 1'b0;
         end
      end
      @(negedge clock);

      // Busy backpressure: req1 in flight, req0 waits then completes with its own operands
      req1_valid = 1'b1; req1_a = 32'd3; req1_b = 32'd3;
      #1;
      chk("bp_rdy1", req1_ready, 1);
      @(negedge clock);
      req1_valid = 1'b0;
      req0_valid = 1'b1; req0_a = 32'hFFFFFFFF; req0_b = 32'd1;
      #1;
      chk("bp_rdy0_cmp", req0_ready, 0);
      chk("bp_busy", busy, 1);
      @(negedge clock);
      #1;
      chk("bp_rv1",  rsp1_valid, 1);
      chk("bp_neq1", rsp1_neq,   0);
      chk("bp_lt1",  rsp1_lt,    0);
      chk("bp_rdy0_idle", req0_ready, 1);
      @(negedge clock);
      req0_valid = 1'b0;
      @(negedge clock);
      chk("bp_rv0",  rsp0_valid, 1);
      chk("bp_neq0", rsp0_neq,   1);
      chk("bp_lt0",  rsp0_lt,    1);
      @(negedge clock);

      // Reset while a compare is in flight
      req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd2;
      #1;
      chk("mr_rdy0", req0_ready, 1);
      @(negedge clock);
      req0_valid = 1'b0;
      reset      = 1'b1;
      #1;
      chk("mr_rdy0_rst", req0_ready, 0);
      @(negedge clock);
      checkAllZero("mr_post");
      reset = 1'b0;
      @(negedge clock);
      chk("mr_nopulse", rsp0_valid, 0);

      // First tie after reset goes to requester 0
      req0_valid = 1'b1; req0_a = 32'd9; req0_b = 32'd4;
      req1_valid = 1'b1; req1_a = 32'd4; req1_b = 32'd9;
      #1;
      chk("mr_tie_rdy0", req0_ready, 1);
      chk("mr_tie_rdy1", req1_ready, 0);
      @(negedge clock);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      @(negedge clock);
      chk("mr_tie_rv0",  rsp0_valid, 1);
      chk("mr_tie_rv1",  rsp1_valid, 0);
      chk("mr_tie_neq0", rsp0_neq,   1);
      chk("mr_tie_lt0",  rsp0_lt,    0);
      @(negedge clock);

      $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
      $finish;
   end

endmodule
